// File: rtl/data_memory_controller_pkg.sv
// CPU-wide data-memory encodings shared with the control unit: load/store codes,
// enable-bit positions, controller FSM states and access-size decoding helpers.
package data_memory_controller_pkg;

  localparam int RD_EN_BIT = 3;
  localparam int WR_EN_BIT = 2;

  localparam logic [2:0] LB_CODE  = 3'b000;
  localparam logic [2:0] LH_CODE  = 3'b001;
  localparam logic [2:0] LW_CODE  = 3'b010;
  localparam logic [2:0] LBU_CODE = 3'b100;
  localparam logic [2:0] LHU_CODE = 3'b101;

  localparam logic [1:0] SB_CODE = 2'b00;
  localparam logic [1:0] SH_CODE = 2'b01;
  localparam logic [1:0] SW_CODE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } dmc_state_e;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } acc_size_e;

  typedef struct packed {
    acc_size_e size;
    logic      is_unsigned;
  } acc_kind_t;

  // Undefined codes decode to SZ_NONE: the access still runs but touches nothing.
  function automatic acc_kind_t decode_kind(input logic       is_write,
                                            input logic [2:0] rd_f3,
                                            input logic [1:0] wr_f2);
    acc_kind_t k;
    k.size        = SZ_NONE;
    k.is_unsigned = 1'b0;
    if (is_write) begin
      case (wr_f2)
        SB_CODE: k.size = SZ_BYTE;
        SH_CODE: k.size = SZ_HALF;
        SW_CODE: k.size = SZ_WORD;
        default: ;
      endcase
    end else begin
      case (rd_f3)
        LB_CODE:  k.size = SZ_BYTE;
        LH_CODE:  k.size = SZ_HALF;
        LW_CODE:  k.size = SZ_WORD;
        LBU_CODE: begin k.size = SZ_BYTE; k.is_unsigned = 1'b1; end
        LHU_CODE: begin k.size = SZ_HALF; k.is_unsigned = 1'b1; end
        default: ;
      endcase
    end
    return k;
  endfunction

  function automatic logic is_misaligned(input acc_size_e size, input logic [1:0] offset);
    return ((size == SZ_WORD) && (offset != 2'b00)) || ((size == SZ_HALF) && offset[0]);
  endfunction

  function automatic logic [1:0] force_align(input acc_size_e size, input logic [1:0] offset);
    logic [1:0] o;
    o = offset;
    if (size == SZ_WORD)      o = 2'b00;
    else if (size == SZ_HALF) o = {offset[1], 1'b0};
    return o;
  endfunction

endpackage

// File: rtl/data_memory_controller_if.sv
// MEM-stage data-memory bus: the pipeline (master) presents requests, the
// controller (slave) answers with load data, the freeze signal and the trap pulse.
interface data_memory_controller_if;

  logic [3:0]  MEM_READ;
  logic [2:0]  MEM_WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSY_WAIT;
  logic        MISALIGNED;

  modport master (
    output MEM_READ, MEM_WRITE, ADDRESS, WRITE_DATA,
    input  READ_DATA, BUSY_WAIT, MISALIGNED
  );

  modport slave (
    input  MEM_READ, MEM_WRITE, ADDRESS, WRITE_DATA,
    output READ_DATA, BUSY_WAIT, MISALIGNED
  );

endinterface

// File: rtl/data_memory_controller_load_store_aligner.sv
// Combinational little-endian lane steering: byte enables and merged word for
// stores, sign/zero-extended lane extraction for loads.
module load_store_aligner
  import data_memory_controller_pkg::*;
(
  input  acc_size_e   size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_value
);

  logic [31:0] lane_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    byte_en   = 4'b0000;
    lane_data = store_data;
    case (size)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << offset;
        lane_data = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        byte_en   = offset[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{store_data[15:0]}};
      end
      SZ_WORD: byte_en = 4'b1111;
      default: ;
    endcase

    store_word = old_word;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) store_word[8*b +: 8] = lane_data[8*b +: 8];
    end
  end

  always_comb begin
    byte_sel   = old_word[{offset, 3'b000} +: 8];
    half_sel   = offset[1] ? old_word[31:16] : old_word[15:0];
    load_value = 32'h0;
    case (size)
      SZ_BYTE: load_value = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_value = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      SZ_WORD: load_value = old_word;
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_controller.sv
// Fixed-latency data-memory responder (IDLE -> ACCESS -> DONE) with sized little-endian
// loads/stores. Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module data_memory_controller
  import data_memory_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input logic                      CLK,
  input logic                      RESET,
  data_memory_controller_if.slave  bus
);

  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [31:0] mem_q [DEPTH];

  dmc_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]            offset_q, offset_d;
  logic [31:0]           wdata_q, wdata_d;
  acc_kind_t             kind_q, kind_d;
  logic                  is_write_q, is_write_d;
  logic                  read_too_q, read_too_d;
  logic                  trap_q, trap_d;
  logic [31:0]           read_data_q, read_data_d;
  logic                  mis_pulse_q, mis_pulse_d;

  logic        req, req_write, busy, mem_we;
  acc_kind_t   req_kind;
  logic [1:0]  req_offset;
  logic [3:0]  byte_en;
  logic [31:0] old_word, store_word, load_value;
  logic        unused_addr_hi;

  assign req_write      = bus.MEM_WRITE[WR_EN_BIT];
  assign req            = bus.MEM_READ[RD_EN_BIT] | req_write;
  assign req_kind       = decode_kind(req_write, bus.MEM_READ[2:0], bus.MEM_WRITE[1:0]);
  assign req_offset     = TRAP_EN ? bus.ADDRESS[1:0] : force_align(req_kind.size, bus.ADDRESS[1:0]);
  assign unused_addr_hi = ^bus.ADDRESS[31:ADDR_WIDTH+2];
  assign old_word       = mem_q[idx_q];

  load_store_aligner u_aligner (
    .size        (kind_q.size),
    .is_unsigned (kind_q.is_unsigned),
    .offset      (offset_q),
    .old_word    (old_word),
    .store_data  (wdata_q),
    .byte_en     (byte_en),
    .store_word  (store_word),
    .load_value  (load_value)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    offset_d    = offset_q;
    wdata_d     = wdata_q;
    kind_d      = kind_q;
    is_write_d  = is_write_q;
    read_too_d  = read_too_q;
    trap_d      = trap_q;
    read_data_d = read_data_q;
    mis_pulse_d = 1'b0;
    busy        = 1'b0;
    mem_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Busy rises combinationally so the pipeline holds on this very edge.
        if (req) begin
          busy       = 1'b1;
          idx_d      = bus.ADDRESS[ADDR_WIDTH+1:2];
          offset_d   = req_offset;
          wdata_d    = bus.WRITE_DATA;
          kind_d     = req_kind;
          is_write_d = req_write;
          read_too_d = bus.MEM_READ[RD_EN_BIT];
          trap_d     = TRAP_EN && is_misaligned(req_kind.size, bus.ADDRESS[1:0]);
          cnt_d      = CNT_LOAD;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        busy = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d     = ST_DONE;
          mis_pulse_d = trap_q;
          if (trap_q) begin
            read_data_d = 32'h0;
          end else if (is_write_q) begin
            mem_we = (kind_q.size != SZ_NONE) && (byte_en != 4'b0000);
            if (read_too_q) read_data_d = 32'h0;
          end else begin
            read_data_d = load_value;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // DONE never looks at the request, so a request held across it cannot re-trigger.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      offset_q    <= 2'b00;
      wdata_q     <= 32'h0;
      kind_q      <= '0;
      is_write_q  <= 1'b0;
      read_too_q  <= 1'b0;
      trap_q      <= 1'b0;
      read_data_q <= 32'h0;
      mis_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      offset_q    <= offset_d;
      wdata_q     <= wdata_d;
      kind_q      <= kind_d;
      is_write_q  <= is_write_d;
      read_too_q  <= read_too_d;
      trap_q      <= trap_d;
      read_data_q <= read_data_d;
      mis_pulse_q <= mis_pulse_d;
    end
  end

  // NOTE: the memory array is never reset; contents survive RESET, and a commit
  // coinciding with RESET is dropped so an aborted store leaves memory untouched.
  always_ff @(posedge CLK) begin
    if (mem_we && !RESET) mem_q[idx_q] <= store_word;
  end

  assign bus.BUSY_WAIT  = busy & ~RESET;
  assign bus.READ_DATA  = read_data_q;
  assign bus.MISALIGNED = mis_pulse_q;

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench for data_memory_controller: table of sized accesses with hand-computed
// results, plus held-request, back-to-back and reset-abort sequences.
module tb_data_memory_controller;

  localparam int LAT = 4;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [3:0] RD_LB  = 4'b1000;
  localparam logic [3:0] RD_LH  = 4'b1001;
  localparam logic [3:0] RD_LW  = 4'b1010;
  localparam logic [3:0] RD_LBU = 4'b1100;
  localparam logic [3:0] RD_LHU = 4'b1101;
  localparam logic [3:0] RD_NO  = 4'b0000;
  localparam logic [2:0] WR_SB  = 3'b100;
  localparam logic [2:0] WR_SH  = 3'b101;
  localparam logic [2:0] WR_SW  = 3'b110;
  localparam logic [2:0] WR_NO  = 3'b000;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  data_memory_controller_if bus();

  data_memory_controller #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  rd;
    logic [2:0]  wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic add(input string name, input logic [3:0] rd, input logic [2:0] wr,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_mis);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.addr = addr;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_mis = exp_mis;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] rd, input logic [2:0] wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.MEM_READ   = rd;
    bus.MEM_WRITE  = wr;
    bus.ADDRESS    = addr;
    bus.WRITE_DATA = wdata;
  endtask

  // Called just after a rising edge; returns just after the DONE edge with inputs idle.
  task automatic run_access(input logic [3:0] rd, input logic [2:0] wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output int busy_n, output logic [31:0] rdata, output logic mis);
    drive(rd, wr, addr, wdata);
    busy_n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.BUSY_WAIT) busy_n++;
      else break;
    end
    rdata = bus.READ_DATA;
    mis   = bus.MISALIGNED;
    @(posedge clk); #1;
    drive(RD_NO, WR_NO, 32'h0, 32'h0);
  endtask

  initial begin
    int          busy_n;
    logic [31:0] rdata;
    logic        mis;

    add("sw_deadbeef",    RD_NO,  WR_SW, 32'h40,       32'hDEADBEEF, 32'h0,        1'b0);
    add("lw_40",          RD_LW,  WR_NO, 32'h40,       32'h0,        32'hDEADBEEF, 1'b0);
    add("sw_zero_40",     RD_NO,  WR_SW, 32'h40,       32'h0,        32'hDEADBEEF, 1'b0);
    add("sb_41",          RD_NO,  WR_SB, 32'h41,       32'hFFFFFF80, 32'hDEADBEEF, 1'b0);
    add("lw_40_post_sb",  RD_LW,  WR_NO, 32'h40,       32'h0,        32'h00008000, 1'b0);
    add("lb_41",          RD_LB,  WR_NO, 32'h41,       32'h0,        32'hFFFFFF80, 1'b0);
    add("lbu_41",         RD_LBU, WR_NO, 32'h41,       32'h0,        32'h00000080, 1'b0);
    add("sw_10",          RD_NO,  WR_SW, 32'h10,       32'h11223344, 32'h00000080, 1'b0);
    add("sh_12",          RD_NO,  WR_SH, 32'h12,       32'hABCD8001, 32'h00000080, 1'b0);
    add("lh_12",          RD_LH,  WR_NO, 32'h12,       32'h0,        32'hFFFF8001, 1'b0);
    add("lhu_12",         RD_LHU, WR_NO, 32'h12,       32'h0,        32'h00008001, 1'b0);
    add("lw_10",          RD_LW,  WR_NO, 32'h10,       32'h0,        32'h80013344, 1'b0);
    add("lb_10",          RD_LB,  WR_NO, 32'h10,       32'h0,        32'h00000044, 1'b0);
    add("lh_10",          RD_LH,  WR_NO, 32'h10,       32'h0,        32'h00003344, 1'b0);
    add("lb_13",          RD_LB,  WR_NO, 32'h13,       32'h0,        32'hFFFFFF80, 1'b0);
    add("lbu_12",         RD_LBU, WR_NO, 32'h12,       32'h0,        32'h00000001, 1'b0);
    add("rd_undef",       4'b1011, WR_NO, 32'h10,      32'h0,        32'h0,        1'b0);
    add("wr_undef",       RD_NO,  3'b111, 32'h10,      32'hFFFFFFFF, 32'h0,        1'b0);
    add("lw_10_post_und", RD_LW,  WR_NO, 32'h10,       32'h0,        32'h80013344, 1'b0);
    add("rd_wr_both",     RD_LW,  WR_SW, 32'h20,       32'hCAFEF00D, 32'h0,        1'b0);
    add("lw_20",          RD_LW,  WR_NO, 32'h20,       32'h0,        32'hCAFEF00D, 1'b0);
    add("sw_wrap",        RD_NO,  WR_SW, 32'h00001020, 32'h5A5A0001, 32'hCAFEF00D, 1'b0);
    add("lw_wrap",        RD_LW,  WR_NO, 32'hFFFF0020, 32'h0,        32'h5A5A0001, 1'b0);
    add("lw_42",          RD_LW,  WR_NO, 32'h42,       32'h0,        TRAP ? 32'h0 : 32'h00008000, TRAP);
    add("lh_13",          RD_LH,  WR_NO, 32'h13,       32'h0,        TRAP ? 32'h0 : 32'hFFFF8001, TRAP);
    add("sh_11",          RD_NO,  WR_SH, 32'h11,       32'h00007777, TRAP ? 32'h0 : 32'hFFFF8001, TRAP);
    add("lw_10_post_sh",  RD_LW,  WR_NO, 32'h10,       32'h0,        TRAP ? 32'h80013344 : 32'h80017777, 1'b0);

    rst = 1'b1;
    drive(RD_NO, WR_NO, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy",  {31'b0, bus.BUSY_WAIT},  32'h0);
    check("reset_rdata", bus.READ_DATA,            32'h0);
    check("reset_mis",   {31'b0, bus.MISALIGNED}, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      run_access(v.rd, v.wr, v.addr, v.wdata, busy_n, rdata, mis);
      check($sformatf("%s busy_cycles", v.name), 32'(busy_n), 32'(LAT + 1));
      check($sformatf("%s read_data", v.name), rdata, v.exp_rdata);
      check($sformatf("%s misaligned", v.name), {31'b0, mis}, {31'b0, v.exp_mis});
      @(negedge clk);
      check($sformatf("%s misaligned_next", v.name), {31'b0, bus.MISALIGNED}, 32'h0);
      @(posedge clk); #1;
    end

    // Request held through DONE, dropped the cycle after: exactly one access.
    drive(RD_LW, WR_NO, 32'h40, 32'h0);
    busy_n = 0;
    for (int c = 0; c <= LAT; c++) begin
      @(negedge clk);
      if (bus.BUSY_WAIT) busy_n++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("held busy_cycles", 32'(busy_n), 32'(LAT + 1));
    check("held done_busy", {31'b0, bus.BUSY_WAIT}, 32'h0);
    check("held read_data", bus.READ_DATA, 32'h00008000);
    @(posedge clk); #1;
    drive(RD_NO, WR_NO, 32'h0, 32'h0);
    @(negedge clk);
    check("held idle_busy_1", {31'b0, bus.BUSY_WAIT}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("held idle_busy_2", {31'b0, bus.BUSY_WAIT}, 32'h0);
    @(posedge clk); #1;

    // Back-to-back loads: the second is presented the cycle after the first DONE.
    run_access(RD_LW, WR_NO, 32'h40, 32'h0, busy_n, rdata, mis);
    check("b2b first busy_cycles", 32'(busy_n), 32'(LAT + 1));
    check("b2b first read_data", rdata, 32'h00008000);
    run_access(RD_LW, WR_NO, 32'h10, 32'h0, busy_n, rdata, mis);
    check("b2b second busy_cycles", 32'(busy_n), 32'(LAT + 1));
    check("b2b second read_data", rdata, TRAP ? 32'h80013344 : 32'h80017777);

    // Reset in cycle 2 of a store aborts it; memory keeps the old word.
    run_access(RD_NO, WR_SW, 32'h80, 32'hA5A5A5A5, busy_n, rdata, mis);
    check("rst_pre busy_cycles", 32'(busy_n), 32'(LAT + 1));
    drive(RD_NO, WR_SW, 32'h80, 32'h12345678);
    @(negedge clk);
    check("rst c0_busy", {31'b0, bus.BUSY_WAIT}, 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    drive(RD_NO, WR_NO, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst after_busy", {31'b0, bus.BUSY_WAIT}, 32'h0);
    check("rst after_rdata", bus.READ_DATA, 32'h0);
    @(posedge clk); #1;
    run_access(RD_LW, WR_NO, 32'h80, 32'h0, busy_n, rdata, mis);
    check("rst lw_80 busy_cycles", 32'(busy_n), 32'(LAT + 1));
    check("rst lw_80 read_data", rdata, 32'hA5A5A5A5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
